// File: rtl/comp_match_monitor_pkg.sv
// Shared definitions for the comparator match monitor.
// - state_e     : FSM state encoding, also exported on the state port
// - *_DEF       : default lock/unlock run lengths and counter width
// - RUN_W       : width of the internal consecutive-sample run counter
// - is_match()  : a sample is a match when both comparator pairs agree
package comp_match_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2,
        ST_SLIP   = 2'd3
    } state_e;

    localparam int LOCK_LEN_DEF   = 4;
    localparam int UNLOCK_LEN_DEF = 2;
    localparam int CNT_W_DEF      = 8;
    localparam int RUN_W          = 4;

    function automatic logic is_match(input logic y1, input logic y2);
        return y1 & y2;
    endfunction

endpackage

// File: rtl/comp_match_monitor_sat_counter.sv
// Saturating up-counter used for the match/miss status totals.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (count -> 0)
//   clr   - synchronous clear, wins over inc
//   inc   - add one unless already at all-ones
//   q     - registered count
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ZERO_C = {W{1'b0}};
    localparam logic [W-1:0] ONE_C  = W'(1'b1);
    localparam logic [W-1:0] MAX_C  = {W{1'b1}};

    logic [W-1:0] q_r;

    // Count register: clear first, then increment with hold at the top value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r <= ZERO_C;
        end else if (clr) begin
            q_r <= ZERO_C;
        end else if (inc && (q_r != MAX_C)) begin
            q_r <= q_r + ONE_C;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/comp_match_monitor.sv
// Monitors the y1/y2 flags of the dual equality comparator and tracks lock.
// Lock is declared after LOCK_LEN consecutive matched samples and dropped
// after UNLOCK_LEN consecutive misses; match/miss totals saturate.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   in_valid        - y1/y2 carry a valid comparator result this cycle
//   y1, y2          - comparator flags (ignored when in_valid=0)
//   clear           - synchronous soft clear of FSM and totals
//   lock            - state is LOCKED or SLIP
//   lock_pulse      - one cycle on SEARCH->LOCKED
//   unlock_pulse    - one cycle on exit to SEARCH from a locked state
//   state           - current FSM state encoding
//   match_total     - saturating count of matched samples
//   miss_total      - saturating count of missed samples
module comp_match_monitor
    import comp_match_monitor_pkg::*;
#(
    parameter int LOCK_LEN   = LOCK_LEN_DEF,
    parameter int UNLOCK_LEN = UNLOCK_LEN_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             y1,
    input  logic             y2,
    input  logic             clear,
    output logic             lock,
    output logic             lock_pulse,
    output logic             unlock_pulse,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] match_total,
    output logic [CNT_W-1:0] miss_total
);

    localparam logic [RUN_W-1:0] LOCK_LEN_C   = RUN_W'(LOCK_LEN);
    localparam logic [RUN_W-1:0] UNLOCK_LEN_C = RUN_W'(UNLOCK_LEN);
    localparam logic [RUN_W-1:0] RUN_ZERO_C   = {RUN_W{1'b0}};
    localparam logic [RUN_W-1:0] RUN_ONE_C    = RUN_W'(1'b1);

    state_e           state_r;
    state_e           next_state_s;
    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] next_run_s;
    logic [RUN_W-1:0] run_inc_s;
    logic             lock_r;
    logic             lock_pulse_r;
    logic             unlock_pulse_r;
    logic             lock_pulse_s;
    logic             unlock_pulse_s;
    logic             match_s;

    assign match_s   = is_match(y1, y2);
    assign run_inc_s = run_r + RUN_ONE_C;

    // Next-state, run counter and pulse decode for one valid sample.
    always_comb begin
        next_state_s   = state_r;
        next_run_s     = run_r;
        lock_pulse_s   = 1'b0;
        unlock_pulse_s = 1'b0;
        if (in_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (match_s && (LOCK_LEN_C == RUN_ONE_C)) begin
                        next_state_s = ST_LOCKED;
                        next_run_s   = RUN_ZERO_C;
                    end else if (match_s) begin
                        next_state_s = ST_SEARCH;
                        next_run_s   = RUN_ONE_C;
                    end else begin
                        next_state_s = ST_SEARCH;
                        next_run_s   = RUN_ZERO_C;
                    end
                end
                ST_SEARCH: begin
                    if (match_s && (run_inc_s == LOCK_LEN_C)) begin
                        next_state_s = ST_LOCKED;
                        next_run_s   = RUN_ZERO_C;
                        lock_pulse_s = 1'b1;
                    end else if (match_s) begin
                        next_run_s   = run_inc_s;
                    end else begin
                        next_run_s   = RUN_ZERO_C;
                    end
                end
                ST_LOCKED: begin
                    // A single miss already counts as the first of the unlock run.
                    if (match_s) begin
                        next_state_s = ST_LOCKED;
                    end else if (UNLOCK_LEN_C == RUN_ONE_C) begin
                        next_state_s   = ST_SEARCH;
                        next_run_s     = RUN_ZERO_C;
                        unlock_pulse_s = 1'b1;
                    end else begin
                        next_state_s = ST_SLIP;
                        next_run_s   = RUN_ONE_C;
                    end
                end
                ST_SLIP: begin
                    if (match_s) begin
                        next_state_s = ST_LOCKED;
                        next_run_s   = RUN_ZERO_C;
                    end else if (run_inc_s == UNLOCK_LEN_C) begin
                        next_state_s   = ST_SEARCH;
                        next_run_s     = RUN_ZERO_C;
                        unlock_pulse_s = 1'b1;
                    end else begin
                        next_run_s   = run_inc_s;
                    end
                end
                default: begin
                    next_state_s = ST_IDLE;
                    next_run_s   = RUN_ZERO_C;
                end
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // FSM state, run counter and registered status outputs; clear beats in_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            run_r          <= RUN_ZERO_C;
            lock_r         <= 1'b0;
            lock_pulse_r   <= 1'b0;
            unlock_pulse_r <= 1'b0;
        end else if (clear) begin
            state_r        <= ST_IDLE;
            run_r          <= RUN_ZERO_C;
            lock_r         <= 1'b0;
            lock_pulse_r   <= 1'b0;
            unlock_pulse_r <= 1'b0;
        end else begin
            state_r        <= next_state_s;
            run_r          <= next_run_s;
            lock_r         <= (next_state_s == ST_LOCKED) || (next_state_s == ST_SLIP);
            lock_pulse_r   <= lock_pulse_s;
            unlock_pulse_r <= unlock_pulse_s;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (in_valid & match_s),
        .q     (match_total)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (in_valid & ~match_s),
        .q     (miss_total)
    );

    assign state        = state_r;
    assign lock         = lock_r;
    assign lock_pulse   = lock_pulse_r;
    assign unlock_pulse = unlock_pulse_r;

endmodule

// File: tb/tb_comp_match_monitor.sv
// Self-checking bench: two monitor instances (default parameters and a
// short-counter / single-miss-unlock variant) driven by the same stimulus and
// compared every cycle against a streak-based behavioural model.
module tb_comp_match_monitor;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic y1;
    logic y2;
    logic clear;

    logic       a_lock, a_lp, a_up;
    logic [1:0] a_state;
    logic [7:0] a_mt, a_ms;
    logic       b_lock, b_lp, b_up;
    logic [1:0] b_state;
    logic [2:0] b_mt, b_ms;

    int n_cmp = 0;
    int n_err = 0;

    // Model parameters per instance: lock length, unlock length, counter max.
    int p_lock[2]   = '{4, 3};
    int p_unlock[2] = '{2, 1};
    int p_max[2]    = '{255, 7};

    // Model state: seen any sample, locked, current streak, totals, pulses.
    bit m_seen[2];
    bit m_locked[2];
    int m_streak[2];
    int m_mt[2];
    int m_ms[2];
    bit m_lp[2];
    bit m_up[2];

    always #5 clk = ~clk;

    comp_match_monitor dut_a (
        .clk (clk), .reset (reset), .in_valid (in_valid), .y1 (y1), .y2 (y2),
        .clear (clear), .lock (a_lock), .lock_pulse (a_lp), .unlock_pulse (a_up),
        .state (a_state), .match_total (a_mt), .miss_total (a_ms)
    );

    comp_match_monitor #(.LOCK_LEN(3), .UNLOCK_LEN(1), .CNT_W(3)) dut_b (
        .clk (clk), .reset (reset), .in_valid (in_valid), .y1 (y1), .y2 (y2),
        .clear (clear), .lock (b_lock), .lock_pulse (b_lp), .unlock_pulse (b_up),
        .state (b_state), .match_total (b_mt), .miss_total (b_ms)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_seen[k] = 1'b0; m_locked[k] = 1'b0; m_streak[k] = 0;
            m_mt[k] = 0; m_ms[k] = 0; m_lp[k] = 1'b0; m_up[k] = 1'b0;
        end
    endtask

    // Lock after p_lock consecutive matches; unlock after p_unlock consecutive misses.
    task automatic model_step(input int k, input bit v, input bit mt, input bit clr);
        m_lp[k] = 1'b0;
        m_up[k] = 1'b0;
        if (clr) begin
            m_seen[k] = 1'b0; m_locked[k] = 1'b0; m_streak[k] = 0;
            m_mt[k] = 0; m_ms[k] = 0;
        end else if (v) begin
            if (mt) m_mt[k] = (m_mt[k] < p_max[k]) ? m_mt[k] + 1 : m_mt[k];
            else    m_ms[k] = (m_ms[k] < p_max[k]) ? m_ms[k] + 1 : m_ms[k];
            if (!m_locked[k]) begin
                m_streak[k] = mt ? m_streak[k] + 1 : 0;
                if (m_streak[k] == p_lock[k]) begin
                    m_locked[k] = 1'b1;
                    m_lp[k]     = m_seen[k];
                    m_streak[k] = 0;
                end
            end else begin
                m_streak[k] = mt ? 0 : m_streak[k] + 1;
                if (m_streak[k] == p_unlock[k]) begin
                    m_locked[k] = 1'b0;
                    m_up[k]     = 1'b1;
                    m_streak[k] = 0;
                end
            end
            m_seen[k] = 1'b1;
        end
    endtask

    function automatic int model_state(input int k);
        if (!m_seen[k])        return 0;
        else if (!m_locked[k]) return 1;
        else if (m_streak[k] > 0) return 3;
        else                   return 2;
    endfunction

    task automatic compare_all();
        check_eq("A.state", 32'(a_state), 32'(model_state(0)));
        check_eq("A.lock",  32'(a_lock),  32'(m_locked[0]));
        check_eq("A.lock_pulse",   32'(a_lp), 32'(m_lp[0]));
        check_eq("A.unlock_pulse", 32'(a_up), 32'(m_up[0]));
        check_eq("A.match_total",  32'(a_mt), 32'(m_mt[0]));
        check_eq("A.miss_total",   32'(a_ms), 32'(m_ms[0]));
        check_eq("B.state", 32'(b_state), 32'(model_state(1)));
        check_eq("B.lock",  32'(b_lock),  32'(m_locked[1]));
        check_eq("B.lock_pulse",   32'(b_lp), 32'(m_lp[1]));
        check_eq("B.unlock_pulse", 32'(b_up), 32'(m_up[1]));
        check_eq("B.match_total",  32'(b_mt), 32'(m_mt[1]));
        check_eq("B.miss_total",   32'(b_ms), 32'(m_ms[1]));
    endtask

    // Drive one sample on the falling edge, check #1 after the capturing edge.
    task automatic cyc(input logic v, input logic a, input logic b, input logic c);
        bit mt;
        @(negedge clk);
        in_valid = v; y1 = a; y2 = b; clear = c;
        mt = (a === 1'b1) && (b === 1'b1);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, v === 1'b1, mt, c === 1'b1);
        #1;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; y1 = 1'b0; y2 = 1'b0; clear = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Four matches -> lock on the fourth.
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        // Single miss then match: SLIP and back to LOCKED.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        // Two misses: unlock.
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        // Run of three, broken by a miss, then four to lock.
        repeat (3) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        // Clear with a valid match on the same edge.
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        // Idle cycles with unknown flags.
        repeat (5) cyc(1'b0, 1'bx, 1'bx, 1'b0);
        // Nine matches: short counter saturates.
        repeat (9) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'bx, 1'bx, 1'b0);
        // Reach SLIP, then asynchronous reset between edges.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b0;

        // Randomised traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0);
        end
        // Long match run: wide counter saturates too.
        repeat (260) cyc(1'b1, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
